// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execution stage: opcodes and FSM states.
// Optional illegal-op reporting is enabled by ALU_EXEC_ILLEGAL_OP_EN.
package alu_exec_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_MUL  = 3'd4,
        OP_ILL5 = 3'd5,
        OP_ILL6 = 3'd6,
        OP_RST  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE,
        CLR
    } alu_exec_state_t;

endpackage

// File: rtl/alu_exec_mul.sv
// Iterative shift-add multiplier: one partial product per cycle for W cycles.
// Control of the sequence lives in alu_exec_unit; this block only iterates.
module alu_exec_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           last,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [2*W-1:0] acc_step;

    // product is the accumulator after this cycle's partial product
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last     = busy_q && (cnt_q == CW'(W - 1));
    assign busy     = busy_q;
    assign product  = acc_step;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle add/and/xor, iterative multiply, clear op.
// Define ALU_EXEC_ILLEGAL_OP_EN to complete ops 5/6 with err instead of no-op.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter  int ALU_IN_OP_WIDTH      = 8,
    localparam int ALU_OUT_RESULT_WIDTH = 2 * ALU_IN_OP_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alu_rst,
    input  logic                            valid,
    output logic                            ready,
    input  logic [2:0]                      op,
    input  logic [ALU_IN_OP_WIDTH-1:0]      a,
    input  logic [ALU_IN_OP_WIDTH-1:0]      b,
    output logic                            done,
    output logic [ALU_OUT_RESULT_WIDTH-1:0] result,
    output logic                            err
);

    localparam int W  = ALU_IN_OP_WIDTH;
    localparam int RW = ALU_OUT_RESULT_WIDTH;

    alu_exec_state_t state_q, state_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [RW-1:0]   result_q, result_d;

    logic            clr;
    logic            mul_start;
    logic            mul_busy;
    logic            mul_last;
    logic [RW-1:0]   mul_product;
    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;

    assign clr   = rst | ~alu_rst;
    assign a_ext = {{W{1'b0}}, a};
    assign b_ext = {{W{1'b0}}, b};

    alu_exec_mul #(.W(W)) u_mul (
        .clk     (clk),
        .clr     (clr),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        result_d  = result_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid && ready_q) begin
                    unique case (alu_op_t'(op))
                        OP_ADD: begin
                            state_d  = DONE;
                            ready_d  = 1'b0;
                            done_d   = 1'b1;
                            result_d = a_ext + b_ext;
                        end
                        OP_AND: begin
                            state_d  = DONE;
                            ready_d  = 1'b0;
                            done_d   = 1'b1;
                            result_d = a_ext & b_ext;
                        end
                        OP_XOR: begin
                            state_d  = DONE;
                            ready_d  = 1'b0;
                            done_d   = 1'b1;
                            result_d = a_ext ^ b_ext;
                        end
                        OP_MUL: begin
                            state_d   = EXEC;
                            ready_d   = 1'b0;
                            mul_start = 1'b1;
                        end
                        OP_RST: begin
                            state_d = CLR;
                            ready_d = 1'b0;
                        end
`ifdef ALU_EXEC_ILLEGAL_OP_EN
                        OP_ILL5, OP_ILL6: begin
                            state_d  = DONE;
                            ready_d  = 1'b0;
                            done_d   = 1'b1;
                            err_d    = 1'b1;
                            result_d = '0;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                // busy check keeps the FSM from stalling if the multiplier idles
                if (mul_last || !mul_busy) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = mul_product;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            CLR: begin
                state_d  = IDLE;
                ready_d  = 1'b1;
                result_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit with directed and random ops.
// Expectations follow ALU_EXEC_ILLEGAL_OP_EN when it is defined.
module tb_alu_exec_unit;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  op = 3'd0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        done;
    logic [15:0] result;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.ALU_IN_OP_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .alu_rst (alu_rst),
        .valid   (valid),
        .ready   (ready),
        .op      (op),
        .a       (a),
        .b       (b),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 30) begin
            tick();
            n++;
        end
        if (!ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout: ready=%0b required=1", ready);
        end
    endtask

    // Issue one op and watch up to win cycles after the accept edge.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input int win,
                          output logic got, output int lat,
                          output logic [15:0] res, output logic eany);
        wait_ready();
        valid = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        valid = 1'b0;
        got = 1'b0;
        lat = 0;
        eany = 1'b0;
        res = result;
        for (int i = 0; i <= win; i++) begin
            eany |= err;
            if (done) begin
                got = 1'b1;
                lat = i;
                res = result;
                break;
            end
            res = result;
            if (i < win) tick();
        end
    endtask

    // Reference behaviour straight from the opcode table.
    task automatic model(input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, inout logic [15:0] r,
                         output logic exp_done, output int exp_lat,
                         output logic exp_err);
        exp_done = 1'b0;
        exp_lat = 0;
        exp_err = 1'b0;
        case (o)
            3'd1: begin r = 16'(int'(x) + int'(y)); exp_done = 1'b1; end
            3'd2: begin r = {8'h00, x & y}; exp_done = 1'b1; end
            3'd3: begin r = {8'h00, x ^ y}; exp_done = 1'b1; end
            3'd4: begin
                r = 16'(int'(x) * int'(y));
                exp_done = 1'b1;
                exp_lat = W;
            end
            3'd7: r = 16'h0000;
`ifdef ALU_EXEC_ILLEGAL_OP_EN
            3'd5, 3'd6: begin
                r = 16'h0000;
                exp_done = 1'b1;
                exp_err = 1'b1;
            end
`endif
            default: ;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got=%0b exp=0", ready);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got=%0b exp=0", done);
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: got=%0b exp=0", err);
        end
        tests_run++;
        if (result !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_result: got=%h exp=0000", result);
        end
        rst = 1'b0;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_ready_first: got=%0b exp=0", ready);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: got=%0b exp=1", ready);
        end
    endtask

    task automatic test_add_carry();
        logic got, eany;
        int lat;
        logic [15:0] res;
        run_op(3'd1, 8'hFF, 8'h01, 12, got, lat, res, eany);
        tests_run++;
        if (got !== 1'b1 || lat != 0) begin
            tests_failed++;
            $display("FAIL add_latency: done=%0b lat=%0d exp done=1 lat=0", got, lat);
        end
        tests_run++;
        if (res !== 16'h0100) begin
            tests_failed++;
            $display("FAIL add_result: got=%h exp=0100", res);
        end
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_ready_in_done: got=%0b exp=0", ready);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_ready_after: ready=%0b done=%0b exp 1/0", ready, done);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        logic busy_ok;
        wait_ready();
        valid = 1'b1;
        op = 3'd4;
        a = 8'hFF;
        b = 8'hFF;
        tick();
        op = 3'd3;
        a = 8'hF0;
        b = 8'h3C;
        busy_ok = 1'b1;
        n = 0;
        while (n < 20) begin
            if (ready) busy_ok = 1'b0;
            if (done) break;
            tick();
            n++;
        end
        tests_run++;
        if (n != W || busy_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_latency: lat=%0d ready_low=%0b exp lat=%0d 1", n, busy_ok, W);
        end
        tests_run++;
        if (result !== 16'hFE01) begin
            tests_failed++;
            $display("FAIL mul_result: got=%h exp=FE01", result);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_ready_after: ready=%0b done=%0b exp 1/0", ready, done);
        end
        tick();
        valid = 1'b0;
        tests_run++;
        if (done !== 1'b1 || result !== 16'h00CC) begin
            tests_failed++;
            $display("FAIL xor_after_busy: done=%0b result=%h exp 1/00CC", done, result);
        end
    endtask

    task automatic test_soft_reset();
        logic saw;
        wait_ready();
        valid = 1'b1;
        op = 3'd4;
        a = 8'h37;
        b = 8'h5A;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        alu_rst = 1'b0;
        tick();
        tests_run++;
        if (done !== 1'b0 || result !== 16'h0000 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL soft_reset_state: done=%0b result=%h ready=%0b exp 0/0000/0",
                     done, result, ready);
        end
        alu_rst = 1'b1;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL soft_release_first: got=%0b exp=0", ready);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL soft_release_ready: got=%0b exp=1", ready);
        end
        saw = 1'b0;
        repeat (12) begin
            saw |= done;
            tick();
        end
        tests_run++;
        if (saw !== 1'b0 || result !== 16'h0000) begin
            tests_failed++;
            $display("FAIL soft_reset_drop: done_seen=%0b result=%h exp 0/0000", saw, result);
        end
    endtask

    task automatic test_rst_op();
        logic got, eany;
        int lat;
        logic [15:0] res;
        run_op(3'd1, 8'hFF, 8'h01, 12, got, lat, res, eany);
        tests_run++;
        if (res !== 16'h0100) begin
            tests_failed++;
            $display("FAIL rstop_pre_add: got=%h exp=0100", res);
        end
        wait_ready();
        valid = 1'b1;
        op = 3'd7;
        tick();
        valid = 1'b0;
        tests_run++;
        if (done !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstop_clr_cycle: done=%0b ready=%0b exp 0/0", done, ready);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || result !== 16'h0000 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstop_after: done=%0b result=%h ready=%0b exp 0/0000/1",
                     done, result, ready);
        end
    endtask

    task automatic test_illegal();
        logic got, eany;
        int lat;
        logic [15:0] res;
        run_op(3'd1, 8'h10, 8'h20, 12, got, lat, res, eany);
        run_op(3'd5, 8'h01, 8'h01, 12, got, lat, res, eany);
`ifdef ALU_EXEC_ILLEGAL_OP_EN
        tests_run++;
        if (got !== 1'b1 || lat != 0 || eany !== 1'b1 || res !== 16'h0000) begin
            tests_failed++;
            $display("FAIL illegal_op: done=%0b lat=%0d err=%0b result=%h exp 1/0/1/0000",
                     got, lat, eany, res);
        end
`else
        tests_run++;
        if (got !== 1'b0 || eany !== 1'b0 || res !== 16'h0030) begin
            tests_failed++;
            $display("FAIL illegal_op: done=%0b err=%0b result=%h exp 0/0/0030",
                     got, eany, res);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] mr;
        logic [2:0]  o;
        logic [7:0]  x, y;
        logic        got, eany, ed, ee;
        int          lat, el;
        logic [15:0] res;
        mr = result;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = 8'($urandom);
            model(o, x, y, mr, ed, el, ee);
            run_op(o, x, y, 12, got, lat, res, eany);
            tests_run++;
            if (got !== ed || (ed && lat != el) || res !== mr || eany !== ee) begin
                tests_failed++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: done=%0b lat=%0d res=%h err=%0b exp %0b/%0d/%h/%0b",
                         i, o, x, y, got, lat, res, eany, ed, el, mr, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_busy_ignore();
        test_soft_reset();
        test_rst_op();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
